// File: rtl/ysyx_22050133_axi_sram.sv
// ---------------------------------------------------------------------------
// ysyx_22050133_axi_sram
//   AXI4 responder memory behind the core's IF/MEM arbiter. Independent read
//   and write FSMs, one outstanding burst each, backed by a word-addressed
//   array of MEM_DEPTH data words starting at byte address BASE_ADDR.
//
// Ports
//   clk / rst                 clock, asynchronous active-low reset
//   axi_aw_*                  write address channel (responder side)
//   axi_w_*                   write data channel
//   axi_b_*                   write response channel
//   axi_ar_*                  read address channel
//   axi_r_*                   read data channel
//
// Beats outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*bytes) are dropped (write)
// or return zero (read) and are reported as DECERR. FIXED bursts hold the
// address; every other burst code advances by 1 << size per beat.
// ---------------------------------------------------------------------------
module ysyx_22050133_axi_sram #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                        clk,
    input  logic                        rst,

    output logic                        axi_aw_ready_o,
    input  logic                        axi_aw_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
    input  logic [7:0]                  axi_aw_len_i,
    input  logic [2:0]                  axi_aw_size_i,
    input  logic [1:0]                  axi_aw_burst_i,

    output logic                        axi_w_ready_o,
    input  logic                        axi_w_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
    input  logic                        axi_w_last_i,

    input  logic                        axi_b_ready_i,
    output logic                        axi_b_valid_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_b_id_o,
    output logic [1:0]                  axi_b_resp_o,

    output logic                        axi_ar_ready_o,
    input  logic                        axi_ar_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i,
    input  logic [7:0]                  axi_ar_len_i,
    input  logic [2:0]                  axi_ar_size_i,
    input  logic [1:0]                  axi_ar_burst_i,

    input  logic                        axi_r_ready_i,
    output logic                        axi_r_valid_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_r_id_o,
    output logic [1:0]                  axi_r_resp_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o,
    output logic                        axi_r_last_o
);

    localparam int STRB_W     = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(MEM_DEPTH * STRB_W);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ------------------------------------------------------------- write side
    w_state_t                  r_wstate;
    logic [AXI_ID_WIDTH-1:0]   r_wid;
    logic [AXI_ADDR_WIDTH-1:0] r_waddr;
    logic [2:0]                r_wsize;
    logic [1:0]                r_wburst;
    logic                      r_werr;

    logic [AXI_ADDR_WIDTH-1:0] w_woff;
    logic                      w_win;
    logic [IDX_W-1:0]          w_widx;
    logic [AXI_ADDR_WIDTH-1:0] w_wnext;
    logic                      w_wen;

    // A single unsigned compare of the offset covers both bounds: addresses
    // below BASE_ADDR wrap to huge offsets.
    assign w_woff  = r_waddr - BASE_ADDR;
    assign w_win   = w_woff < SPAN;
    assign w_widx  = w_woff[BYTE_SHIFT +: IDX_W];
    assign w_wnext = (r_wburst == 2'b00) ? r_waddr
                                         : r_waddr + (AXI_ADDR_WIDTH'(1) << r_wsize);
    assign w_wen   = (r_wstate == W_DATA) && axi_w_valid_i && w_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate <= W_IDLE;
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_werr   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (axi_aw_valid_i) begin
                    r_wid    <= axi_aw_id_i;
                    r_waddr  <= axi_aw_addr_i;
                    r_wsize  <= axi_aw_size_i;
                    r_wburst <= axi_aw_burst_i;
                    r_werr   <= 1'b0;
                    r_wstate <= W_DATA;
                end
                // Burst ends on w_last alone; aw_len is not tracked.
                W_DATA: if (axi_w_valid_i) begin
                    if (!w_win) r_werr <= 1'b1;
                    r_waddr <= w_wnext;
                    if (axi_w_last_i) r_wstate <= W_RESP;
                end
                W_RESP: if (axi_b_ready_i) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Memory is deliberately not reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (w_wen) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_w_strb_i[b]) r_mem[w_widx][b*8 +: 8] <= axi_w_data_i[b*8 +: 8];
            end
        end
    end

    assign axi_aw_ready_o = (r_wstate == W_IDLE);
    assign axi_w_ready_o  = (r_wstate == W_DATA);
    assign axi_b_valid_o  = (r_wstate == W_RESP);
    assign axi_b_id_o     = r_wid;
    assign axi_b_resp_o   = (axi_b_valid_o && r_werr) ? 2'b11 : 2'b00;

    // -------------------------------------------------------------- read side
    r_state_t                  r_rstate;
    logic [AXI_ID_WIDTH-1:0]   r_rid;
    logic [AXI_ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]                r_rlen;
    logic [7:0]                r_rcnt;
    logic [2:0]                r_rsize;
    logic [1:0]                r_rburst;

    logic [AXI_ADDR_WIDTH-1:0] w_roff;
    logic                      w_rin;
    logic [IDX_W-1:0]          w_ridx;
    logic [AXI_ADDR_WIDTH-1:0] w_rnext;
    logic                      w_rvalid;
    logic                      w_rlast;

    assign w_roff   = r_raddr - BASE_ADDR;
    assign w_rin    = w_roff < SPAN;
    assign w_ridx   = w_roff[BYTE_SHIFT +: IDX_W];
    assign w_rnext  = (r_rburst == 2'b00) ? r_raddr
                                          : r_raddr + (AXI_ADDR_WIDTH'(1) << r_rsize);
    assign w_rvalid = (r_rstate == R_DATA);
    assign w_rlast  = w_rvalid && (r_rcnt == r_rlen);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (axi_ar_valid_i) begin
                    r_rid    <= axi_ar_id_i;
                    r_raddr  <= axi_ar_addr_i;
                    r_rlen   <= axi_ar_len_i;
                    r_rsize  <= axi_ar_size_i;
                    r_rburst <= axi_ar_burst_i;
                    r_rcnt   <= '0;
                    r_rstate <= R_DATA;
                end
                // Counter stops at len, so len=255 never overflows it.
                R_DATA: if (axi_r_ready_i) begin
                    if (w_rlast) begin
                        r_rstate <= R_IDLE;
                    end else begin
                        r_rcnt  <= r_rcnt + 8'd1;
                        r_raddr <= w_rnext;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Outputs are decoded from held state, so they stay stable under stall.
    assign axi_ar_ready_o = (r_rstate == R_IDLE);
    assign axi_r_valid_o  = w_rvalid;
    assign axi_r_id_o     = r_rid;
    assign axi_r_last_o   = w_rlast;
    assign axi_r_resp_o   = (w_rvalid && !w_rin) ? 2'b11 : 2'b00;
    assign axi_r_data_o   = (w_rvalid && w_rin) ? r_mem[w_ridx] : '0;

    logic w_unused;
    assign w_unused = ^axi_aw_len_i;

endmodule

// File: tb/tb_ysyx_22050133_axi_sram.sv
module tb_ysyx_22050133_axi_sram;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        aw_ready, aw_valid;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_ready, w_valid, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_ready, b_valid;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_ready, ar_valid;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_ready, r_valid, r_last;
    logic [3:0]  r_id;
    logic [1:0]  r_resp;
    logic [63:0] r_data;

    ysyx_22050133_axi_sram dut (
        .clk(clk), .rst(rst),
        .axi_aw_ready_o(aw_ready), .axi_aw_valid_i(aw_valid), .axi_aw_id_i(aw_id),
        .axi_aw_addr_i(aw_addr), .axi_aw_len_i(aw_len), .axi_aw_size_i(aw_size),
        .axi_aw_burst_i(aw_burst),
        .axi_w_ready_o(w_ready), .axi_w_valid_i(w_valid), .axi_w_data_i(w_data),
        .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
        .axi_b_ready_i(b_ready), .axi_b_valid_o(b_valid), .axi_b_id_o(b_id),
        .axi_b_resp_o(b_resp),
        .axi_ar_ready_o(ar_ready), .axi_ar_valid_i(ar_valid), .axi_ar_id_i(ar_id),
        .axi_ar_addr_i(ar_addr), .axi_ar_len_i(ar_len), .axi_ar_size_i(ar_size),
        .axi_ar_burst_i(ar_burst),
        .axi_r_ready_i(r_ready), .axi_r_valid_o(r_valid), .axi_r_id_o(r_id),
        .axi_r_resp_o(r_resp), .axi_r_data_o(r_data), .axi_r_last_o(r_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] model [256];

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;
    rbeat_t exp_q[$];

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'h800;
    endfunction

    function automatic logic [7:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 3;
        return off[7:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        @(negedge clk);
        aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        while (aw_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("aw_ready_wait", aw_ready, 1);
        @(posedge clk); #1 aw_valid = 0;
        @(negedge clk);
        check("w_ready_latency", w_ready, 1);
        check("aw_ready_busy", aw_ready, 0);
    endtask

    task automatic do_w(input logic [31:0] addr, input logic [63:0] data,
                        input logic [7:0] strb, input logic last);
        int t = 0;
        @(negedge clk);
        w_valid = 1; w_data = data; w_strb = strb; w_last = last;
        while (w_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("w_ready_wait", w_ready, 1);
        @(posedge clk);
        if (in_range(addr))
            for (int b = 0; b < 8; b++)
                if (strb[b]) model[widx(addr)][b*8 +: 8] = data[b*8 +: 8];
        #1 w_valid = 0; w_last = 0;
    endtask

    task automatic do_b(input logic [3:0] id, input logic [1:0] resp);
        int t = 0;
        @(negedge clk);
        b_ready = 1;
        while (b_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("b_valid", b_valid, 1);
        check("b_id", b_id, id);
        check("b_resp", b_resp, resp);
        @(posedge clk); #1 b_ready = 0;
        @(negedge clk);
        check("b_valid_drop", b_valid, 0);
        check("aw_ready_after_b", aw_ready, 1);
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        logic [31:0] a;
        rbeat_t e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = in_range(a) ? model[widx(a)] : 64'h0;
            e.resp = in_range(a) ? 2'b00 : 2'b11;
            e.last = (i == int'(len));
            e.id   = id;
            exp_q.push_back(e);
            if (burst != 2'b00) a = a + (32'd1 << size);
        end
        @(negedge clk);
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        while (ar_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        check("ar_ready_wait", ar_ready, 1);
        @(posedge clk); #1 ar_valid = 0;
        @(negedge clk);
        check("r_valid_latency", r_valid, 1);
        check("ar_ready_busy", ar_ready, 0);
    endtask

    // Entered at a negedge. pat[cyc%4] drives r_ready each cycle; stalled
    // beats are compared against the head of the scoreboard too.
    task automatic collect(input int nbeats, input logic [3:0] pat);
        int got = 0;
        int cyc = 0;
        rbeat_t e;
        while (got < nbeats && cyc < 300) begin
            r_ready = pat[cyc % 4];
            if (r_valid === 1'b1 && exp_q.size() == 0) begin
                check("r_unexpected_beat", r_valid, 0);
            end else if (r_valid === 1'b1) begin
                e = exp_q[0];
                check(r_ready ? "r_data" : "r_data_hold", r_data, e.data);
                check(r_ready ? "r_resp" : "r_resp_hold", r_resp, e.resp);
                check(r_ready ? "r_last" : "r_last_hold", r_last, e.last);
                check(r_ready ? "r_id"   : "r_id_hold",   r_id,   e.id);
                if (r_ready) begin
                    void'(exp_q.pop_front());
                    got++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("r_beats_received", got, nbeats);
        r_ready = 0;
    endtask

    task automatic read_done();
        check("r_valid_after_last", r_valid, 0);
        check("ar_ready_after_last", ar_ready, 1);
    endtask

    initial begin
        rbeat_t e;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        r_ready = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_aw_ready", aw_ready, 1);
        check("rst_ar_ready", ar_ready, 1);
        check("rst_w_ready", w_ready, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_id", b_id, 0);
        check("rst_b_resp", b_resp, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_last", r_last, 0);
        check("rst_r_data", r_data, 0);
        check("rst_r_id", r_id, 0);
        check("rst_r_resp", r_resp, 0);
        rst = 1;

        // Word 0 known value (used later to show out-of-range writes land nowhere)
        do_aw(4'd1, BASE, 8'd0, 3'd3, 2'b01);
        do_w(BASE, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 1);
        do_b(4'd1, 2'b00);

        // Single write then read
        do_aw(4'd5, 32'h8000_0010, 8'd0, 3'd3, 2'b01);
        do_w(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1);
        do_b(4'd5, 2'b00);
        check("t1_model", model[2], 64'h1122_3344_5566_7788);
        do_ar(4'd5, 32'h8000_0010, 8'd0, 3'd3, 2'b01);
        collect(1, 4'b1111);
        read_done();

        // 4-beat INCR, prefill all-ones, beat 2 partial strobe, read with stalls
        do_aw(4'd2, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++)
            do_w(32'h8000_0100 + 32'(i*8), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, i == 3);
        do_b(4'd2, 2'b00);
        do_aw(4'd3, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++)
            do_w(32'h8000_0100 + 32'(i*8), 64'h0123_4567_89AB_CD00 + 64'(i),
                 (i == 1) ? 8'h0F : 8'hFF, i == 3);
        do_b(4'd3, 2'b00);
        check("t2_strobe_model", model[33], 64'hFFFF_FFFF_89AB_CD01);
        do_ar(4'd3, 32'h8000_0100, 8'd3, 3'd3, 2'b01);
        collect(4, 4'b1001);
        read_done();

        // size=2 INCR: two 4-byte beats hit the same word
        do_ar(4'd4, 32'h8000_0100, 8'd1, 3'd2, 2'b01);
        collect(2, 4'b1111);
        read_done();

        // FIXED write: both beats land in the same word, second wins
        do_aw(4'd6, 32'h8000_0200, 8'd1, 3'd3, 2'b00);
        do_w(32'h8000_0200, 64'h1111_1111_1111_1111, 8'hFF, 0);
        do_w(32'h8000_0200, 64'h2222_2222_2222_2222, 8'hF0, 1);
        do_b(4'd6, 2'b00);
        do_ar(4'd6, 32'h8000_0200, 8'd2, 3'd3, 2'b00);
        collect(3, 4'b1111);
        read_done();

        // Out of range write just past the top, and read below the base
        do_aw(4'd3, 32'h8000_0800, 8'd0, 3'd3, 2'b01);
        do_w(32'h8000_0800, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1);
        do_b(4'd3, 2'b11);
        do_ar(4'd3, BASE, 8'd0, 3'd3, 2'b01);
        collect(1, 4'b1111);
        do_ar(4'd7, 32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01);
        collect(1, 4'b1111);
        read_done();

        // Burst crossing the top: first beat commits, second errors
        do_aw(4'd9, 32'h8000_07F8, 8'd1, 3'd3, 2'b01);
        do_w(32'h8000_07F8, 64'hCAFE_F00D_0000_7F8A, 8'hFF, 0);
        do_w(32'h8000_0800, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 1);
        do_b(4'd9, 2'b11);
        do_ar(4'd9, 32'h8000_07F8, 8'd1, 3'd3, 2'b01);
        collect(2, 4'b1111);
        read_done();

        // Concurrent AW and AR in the same cycle
        e.data = model[2]; e.resp = 2'b00; e.last = 1'b1; e.id = 4'd7;
        exp_q.push_back(e);
        @(negedge clk);
        aw_valid = 1; aw_id = 4'd6; aw_addr = 32'h8000_0300; aw_len = 0; aw_size = 3; aw_burst = 1;
        ar_valid = 1; ar_id = 4'd7; ar_addr = 32'h8000_0010; ar_len = 0; ar_size = 3; ar_burst = 1;
        check("cc_aw_ready", aw_ready, 1);
        check("cc_ar_ready", ar_ready, 1);
        @(posedge clk); #1 aw_valid = 0; ar_valid = 0;
        @(negedge clk);
        check("cc_w_ready", w_ready, 1);
        collect(1, 4'b1111);
        read_done();
        do_w(32'h8000_0300, 64'h3333_4444_5555_6666, 8'hFF, 1);
        do_b(4'd6, 2'b00);
        do_ar(4'd6, 32'h8000_0300, 8'd0, 3'd3, 2'b01);
        collect(1, 4'b1111);

        // B stall
        do_aw(4'd8, 32'h8000_0400, 8'd0, 3'd3, 2'b01);
        do_w(32'h8000_0400, 64'h0404_0404_0404_0404, 8'hFF, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bstall_b_valid", b_valid, 1);
            check("bstall_b_id", b_id, 8);
            check("bstall_b_resp", b_resp, 0);
            check("bstall_aw_ready", aw_ready, 0);
        end
        do_b(4'd8, 2'b00);

        // Reset in the middle of an 8-beat read
        do_aw(4'd9, 32'h8000_0500, 8'd7, 3'd3, 2'b01);
        for (int i = 0; i < 8; i++)
            do_w(32'h8000_0500 + 32'(i*8), {32'h5000_0000 + 32'(i), 32'hC0DE_0000 + 32'(i)}, 8'hFF, i == 7);
        do_b(4'd9, 2'b00);
        do_ar(4'd9, 32'h8000_0500, 8'd7, 3'd3, 2'b01);
        collect(2, 4'b1111);
        check("mid_r_valid", r_valid, 1);
        #2 rst = 0;
        #1;
        check("rstmid_r_valid", r_valid, 0);
        check("rstmid_r_last", r_last, 0);
        check("rstmid_ar_ready", ar_ready, 1);
        check("rstmid_aw_ready", aw_ready, 1);
        exp_q.delete();
        @(negedge clk); rst = 1;
        do_ar(4'd9, 32'h8000_0500, 8'd7, 3'd3, 2'b01);
        collect(8, 4'b1111);
        read_done();
        do_ar(4'd5, 32'h8000_0010, 8'd0, 3'd3, 2'b01);
        collect(1, 4'b1111);
        read_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
